// File: rtl/addsub_pkg.sv
// Shared opcode encoding and overflow helper for the add/subtract accumulator block.
package addsub_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_ACC_ADD = 3'd2,
        OP_ACC_SUB = 3'd3,
        OP_CLR     = 3'd4
    } op_t;

    // Two's complement overflow from the operand and result sign bits.
    function automatic logic calc_sov(
        input logic a_msb,
        input logic b_msb,
        input logic f_msb,
        input logic sub
    );
        logic sov_v;
        if (sub) begin
            sov_v = (a_msb & ~b_msb & ~f_msb) | (~a_msb & b_msb & f_msb);
        end else begin
            sov_v = (~a_msb & ~b_msb & f_msb) | (a_msb & b_msb & ~f_msb);
        end
        return sov_v;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor with carry/borrow and signed overflow outputs.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] f,
    output logic             uov,
    output logic             sov
);

    logic [WIDTH:0] r_s;

    // Extended-width arithmetic; the top bit is carry for add and borrow for subtract.
    always_comb begin
        if (sub) begin
            r_s = {1'b0, a} - {1'b0, b};
        end else begin
            r_s = {1'b0, a} + {1'b0, b};
        end
        f   = r_s[WIDTH-1:0];
        uov = r_s[WIDTH];
        sov = calc_sov(a[WIDTH-1], b[WIDTH-1], r_s[WIDTH-1], sub);
    end

endmodule

// File: rtl/addsub_accum_pipe.sv
// Registered add/subtract unit with valid/ready handshake, accumulator and sticky overflow flags.
module addsub_accum_pipe
    import addsub_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_uov,
    output logic             out_sov,
    output logic [WIDTH-1:0] acc,
    output logic             sticky_uov,
    output logic             sticky_sov,
    input  logic             sticky_clr
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_f_r;
    logic             out_uov_r;
    logic             out_sov_r;
    logic [WIDTH-1:0] acc_r;
    logic             sticky_uov_r;
    logic             sticky_sov_r;

    logic             acc_op_s;
    logic             sub_s;
    logic             clr_s;
    logic             accept_s;
    logic             out_fire_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] core_f_s;
    logic             core_uov_s;
    logic             core_sov_s;
    logic [WIDTH-1:0] f_next_s;
    logic             uov_next_s;
    logic             sov_next_s;

    assign in_ready   = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign out_fire_s = out_valid_r && out_ready;

    assign out_valid  = out_valid_r;
    assign out_f      = out_f_r;
    assign out_uov    = out_uov_r;
    assign out_sov    = out_sov_r;
    assign acc        = acc_r;
    assign sticky_uov = sticky_uov_r;
    assign sticky_sov = sticky_sov_r;

    // Opcode decode; unknown encodings fall back to a plain add.
    always_comb begin
        acc_op_s = 1'b0;
        sub_s    = 1'b0;
        clr_s    = 1'b0;
        case (in_op)
            OP_ADD: begin
                sub_s = 1'b0;
            end
            OP_SUB: begin
                sub_s = 1'b1;
            end
            OP_ACC_ADD: begin
                acc_op_s = 1'b1;
            end
            OP_ACC_SUB: begin
                acc_op_s = 1'b1;
                sub_s    = 1'b1;
            end
            OP_CLR: begin
                clr_s = 1'b1;
            end
            default: begin
                sub_s = 1'b0;
            end
        endcase
    end

    // Accumulate ops take the live accumulator as A, so back-to-back ops chain without stalls.
    always_comb begin
        if (acc_op_s) begin
            a_s = acc_r;
        end else begin
            a_s = in_a;
        end
    end

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a_s),
        .b   (in_b),
        .sub (sub_s),
        .f   (core_f_s),
        .uov (core_uov_s),
        .sov (core_sov_s)
    );

    // Clear emits the reset accumulator value with both overflow flags low.
    always_comb begin
        if (clr_s) begin
            f_next_s   = ACC_INIT;
            uov_next_s = 1'b0;
            sov_next_s = 1'b0;
        end else begin
            f_next_s   = core_f_s;
            uov_next_s = core_uov_s;
            sov_next_s = core_sov_s;
        end
    end

    // Output register: loads on input transfer, empties on output transfer, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_f_r     <= {WIDTH{1'b0}};
            out_uov_r   <= 1'b0;
            out_sov_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_f_r     <= f_next_s;
            out_uov_r   <= uov_next_s;
            out_sov_r   <= sov_next_s;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Accumulator updates on the same edge its result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= ACC_INIT;
        end else if (accept_s && clr_s) begin
            acc_r <= ACC_INIT;
        end else if (accept_s && acc_op_s) begin
            acc_r <= core_f_s;
        end
    end

    // Sticky flags: a new overflow beats sticky_clr, an accepted clear op beats everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_uov_r <= 1'b0;
            sticky_sov_r <= 1'b0;
        end else if (accept_s && clr_s) begin
            sticky_uov_r <= 1'b0;
            sticky_sov_r <= 1'b0;
        end else begin
            sticky_uov_r <= (sticky_uov_r & ~sticky_clr) | (accept_s & uov_next_s);
            sticky_sov_r <= (sticky_sov_r & ~sticky_clr) | (accept_s & sov_next_s);
        end
    end

endmodule

// File: tb/tb_addsub_accum_pipe.sv
// Directed plus random stimulus for addsub_accum_pipe, checked against an integer reference model.
module tb_addsub_accum_pipe;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_f;
    logic         out_uov;
    logic         out_sov;
    logic [W-1:0] acc;
    logic         sticky_uov;
    logic         sticky_sov;
    logic         sticky_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_valid, m_f, m_uov, m_sov, m_acc, m_stu, m_sts;

    addsub_accum_pipe #(.WIDTH(W), .ACC_INIT(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .out_uov    (out_uov),
        .out_sov    (out_sov),
        .acc        (acc),
        .sticky_uov (sticky_uov),
        .sticky_sov (sticky_sov),
        .sticky_clr (sticky_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Arithmetic meaning of each op, in plain integers.
    task automatic ref_op(input int op, input int a, input int b, input int acc_in,
                          output int f, output int uov, output int sov, output int nacc);
        int  av, sr, r;
        bit  is_acc, is_sub;
        is_acc = (op == 2) || (op == 3);
        is_sub = (op == 1) || (op == 3);
        av = is_acc ? acc_in : a;
        if (op == 4) begin
            f = 0; uov = 0; sov = 0; nacc = 0;
        end else begin
            r   = is_sub ? av - b : av + b;
            sr  = is_sub ? to_signed(av) - to_signed(b) : to_signed(av) + to_signed(b);
            f   = ((r % M) + M) % M;
            uov = is_sub ? int'(av < b) : int'(r >= M);
            sov = int'(sr > M / 2 - 1 || sr < -(M / 2));
            nacc = is_acc ? f : acc_in;
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_f = 0; m_uov = 0; m_sov = 0; m_acc = 0; m_stu = 0; m_sts = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), m_valid);
        check({tag, ".out_f"}, int'(out_f), m_f);
        check({tag, ".out_uov"}, int'(out_uov), m_uov);
        check({tag, ".out_sov"}, int'(out_sov), m_sov);
        check({tag, ".acc"}, int'(acc), m_acc);
        check({tag, ".sticky_uov"}, int'(sticky_uov), m_stu);
        check({tag, ".sticky_sov"}, int'(sticky_sov), m_sts);
    endtask

    // One clock: drive inputs, check in_ready, clock, advance the model, check outputs.
    task automatic cycle(input string tag, input int v, input int op, input int a, input int b,
                         input int ordy, input int sclr);
        int ready, accept, fire, f, uov, sov, nacc;
        in_valid   = v[0];
        in_op      = op[2:0];
        in_a       = a[W-1:0];
        in_b       = b[W-1:0];
        out_ready  = ordy[0];
        sticky_clr = sclr[0];
        #1;
        ready  = int'(m_valid == 0 || ordy != 0);
        check({tag, ".in_ready"}, int'(in_ready), ready);
        accept = int'(v != 0 && ready != 0);
        fire   = int'(m_valid != 0 && ordy != 0);
        @(posedge clk);
        ref_op((op > 4) ? 0 : op, a, b, m_acc, f, uov, sov, nacc);
        if (accept != 0 && op == 4) begin
            m_stu = 0; m_sts = 0;
        end else begin
            m_stu = (sclr != 0 ? 0 : m_stu) | (accept & uov);
            m_sts = (sclr != 0 ? 0 : m_sts) | (accept & sov);
        end
        if (accept != 0) begin
            m_valid = 1; m_f = f; m_uov = uov; m_sov = sov; m_acc = nacc;
        end else if (fire != 0) begin
            m_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        out_ready = 1'b1; sticky_clr = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        check("reset.in_ready", int'(in_ready), 1);
        rst = 1'b0;

        // 1: add carry / signed overflow
        cycle("add7p1", 1, 0, 7, 1, 1, 0);
        check("add7p1.f_const", int'(out_f), 8);
        cycle("add15p1", 1, 0, 15, 1, 1, 0);
        check("add15p1.uov_const", int'(out_uov), 1);
        // 2: subtract borrow / signed overflow
        cycle("sub3m5", 1, 1, 3, 5, 1, 0);
        check("sub3m5.f_const", int'(out_f), 14);
        cycle("sub8m1", 1, 1, 8, 1, 1, 0);
        check("sub8m1.sov_const", int'(out_sov), 1);
        // 3: back-to-back accumulate
        cycle("acc5", 1, 2, 9, 5, 1, 0);
        cycle("acc12", 1, 2, 9, 12, 1, 0);
        cycle("accm2", 1, 3, 9, 2, 1, 0);
        check("acc_chain.acc_const", int'(acc), 15);
        // 4: output stall with pending input
        cycle("stall0", 1, 2, 0, 3, 0, 0);
        cycle("stall1", 1, 0, 2, 2, 0, 0);
        cycle("stall2", 1, 1, 6, 2, 0, 0);
        cycle("release0", 1, 0, 2, 2, 1, 0);
        cycle("release1", 1, 1, 6, 2, 1, 0);
        cycle("drain", 0, 0, 0, 0, 1, 0);
        // 5: sticky_clr racing a fresh overflow, then clear op
        cycle("sclr_race", 1, 0, 15, 1, 1, 1);
        check("sclr_race.stu_const", int'(sticky_uov), 1);
        cycle("sclr_only", 0, 0, 0, 0, 1, 1);
        cycle("clr_op", 1, 4, 5, 5, 1, 0);
        // undefined opcodes behave as add
        cycle("undef5", 1, 5, 9, 9, 1, 0);
        cycle("undef7", 1, 7, 3, 4, 1, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7) == 0));
        end

        // 6: reset while holding a stalled result
        cycle("pre_rst_acc", 1, 2, 0, 9, 0, 0);
        cycle("pre_rst_ovf", 1, 0, 8, 8, 1, 0);
        cycle("pre_rst_stall", 1, 2, 0, 9, 0, 0);
        out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        rst = 1'b0;
        cycle("post_rst", 1, 2, 0, 6, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
